// File: rtl/onehot_index_scanner_if.sv
// onehot_index_scanner_if
//   Bundles the vector-in / index-out handshakes of onehot_index_scanner.
//   master: producer of vectors and consumer of indices (drives in_valid,
//           in_vec, out_ready).
//   slave : the scanner itself (drives in_ready, out_valid, out_index,
//           out_last, out_remaining, zero_drop).
//
//   in_valid/in_ready/in_vec       : vector input handshake (DEPTH-bit flags)
//   out_valid/out_ready/out_index  : index output handshake (BITS-bit index)
//   out_last                       : current index is the final one of the vector
//   out_remaining                  : set bits still pending, current one included
//   zero_drop                      : one-cycle pulse when an all-zero vector is discarded
interface onehot_index_scanner_if #(
    parameter int DEPTH = 8,
    parameter int BITS  = $clog2(DEPTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [DEPTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_index;
    logic             out_last;
    logic [BITS:0]    out_remaining;
    logic             zero_drop;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_index, out_last, out_remaining, zero_drop
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_index, out_last, out_remaining, zero_drop
    );
endinterface

// File: rtl/onehot_index_scanner.sv
// onehot_index_scanner
//   Accepts a DEPTH-bit flag vector and streams out the index of every set
//   bit, lowest first, one per output handshake. All-zero vectors are
//   swallowed and flagged with a one-cycle zero_drop pulse.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : onehot_index_scanner_if.slave (see interface header for fields)
//
//   Every output is decoded from state_q/pending_q/zero_drop_q only, so there
//   is no combinational path from any input to any output.
module onehot_index_scanner #(
    parameter int DEPTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    onehot_index_scanner_if.slave  bus
);
    localparam int BITS = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] pending_q, pending_d;
    logic             zero_drop_q, zero_drop_d;

    logic [BITS-1:0]  low_idx;
    logic [BITS:0]    pop_cnt;
    logic             is_scan;
    logic             is_last;

    // Lowest set bit: walk high to low so the last hit wins.
    always_comb begin
        low_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = BITS'(i);
        end
    end

    // Population count; BITS+1 wide so the all-ones vector (DEPTH) fits.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pop_cnt = pop_cnt + {{BITS{1'b0}}, pending_q[i]};
        end
    end

    assign is_scan = (state_q == SCAN);
    assign is_last = (pop_cnt == (BITS+1)'(1));

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (|bus.in_vec) begin
                        pending_d = bus.in_vec;
                        state_d   = SCAN;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    // x & (x-1) clears exactly the lowest set bit, i.e. low_idx.
                    pending_d = pending_q & (pending_q - DEPTH'(1));
                    if (is_last) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    // Index outputs are forced to zero outside SCAN so IDLE is clean even if
    // pending_q were ever non-zero there.
    assign bus.in_ready      = ~is_scan;
    assign bus.out_valid     = is_scan;
    assign bus.out_index     = is_scan ? low_idx : '0;
    assign bus.out_last      = is_scan & is_last;
    assign bus.out_remaining = is_scan ? pop_cnt : '0;
    assign bus.zero_drop     = zero_drop_q;

endmodule

// File: tb/tb_onehot_index_scanner.sv
module tb_onehot_index_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    onehot_index_scanner_if #(.DEPTH(8)) bus ();

    onehot_index_scanner #(.DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {out_valid, in_ready, out_index, out_last, out_remaining}
    logic [9:0] obs;
    assign obs = {bus.out_valid, bus.in_ready, bus.out_index, bus.out_last, bus.out_remaining};

    function automatic logic [9:0] w(input logic v, input logic r, input int idx,
                                     input logic last, input int rem);
        logic [2:0] i3;
        logic [3:0] r4;
        i3 = idx[2:0];
        r4 = rem[3:0];
        return {v, r, i3, last, r4};
    endfunction

    // Vector is accepted at the second posedge; returns #1 after that edge.
    task automatic load(input logic [7:0] v);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_vec   = v;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (obs !== w(0, 1, 0, 0, 0) || bus.zero_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: got %h zd=%b want %h zd=0", obs, bus.zero_drop, w(0,1,0,0,0));
        end
        #10 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        load(8'hFF);
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 0, 0, 8)) begin
            errors++;
            $display("FAIL reset_prescan: got %h want %h", obs, w(1,0,0,0,8));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, w(0,1,0,0,0));
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, w(0,1,0,0,0));
        end
    endtask

    task automatic test_stream;
        int e_idx[3] = '{2, 5, 7};
        bus.out_ready = 1'b1;
        load(8'b1010_0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== w(1, 0, e_idx[k], k == 2, 3 - k)) begin
                errors++;
                $display("FAIL stream[%0d]: got %h want %h", k, obs, w(1,0,e_idx[k],k==2,3-k));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL stream_idle: got %h want %h", obs, w(0,1,0,0,0));
        end
    endtask

    task automatic test_stall;
        int e_idx[3] = '{2, 5, 7};
        bus.out_ready = 1'b0;
        load(8'b1010_0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== w(1, 0, 2, 0, 3)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", c, obs, w(1,0,2,0,3));
            end
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== w(1, 0, e_idx[k], k == 2, 3 - k)) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got %h want %h", k, obs, w(1,0,e_idx[k],k==2,3-k));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL stall_idle: got %h want %h", obs, w(0,1,0,0,0));
        end
    endtask

    task automatic test_zero;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'h00;
        @(posedge clk); #1;                 // first zero accepted; second presented
        @(negedge clk);
        checks++;
        if (bus.zero_drop !== 1'b1 || obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_first: got zd=%b %h want zd=1 %h", bus.zero_drop, obs, w(0,1,0,0,0));
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.zero_drop !== 1'b1 || obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_second: got zd=%b %h want zd=1 %h", bus.zero_drop, obs, w(0,1,0,0,0));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.zero_drop !== 1'b0 || obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_end: got zd=%b %h want zd=0 %h", bus.zero_drop, obs, w(0,1,0,0,0));
        end
    endtask

    task automatic test_full;
        bus.out_ready = 1'b1;
        load(8'hFF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== w(1, 0, k, k == 7, 8 - k)) begin
                errors++;
                $display("FAIL full[%0d]: got %h want %h", k, obs, w(1,0,k,k==7,8-k));
            end
            @(posedge clk);
        end
        load(8'h80);
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 7, 1, 1)) begin
            errors++;
            $display("FAIL single_msb: got %h want %h", obs, w(1,0,7,1,1));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL single_idle: got %h want %h", obs, w(0,1,0,0,0));
        end
    endtask

    task automatic test_reset_midscan;
        bus.out_ready = 1'b1;
        load(8'b1010_0100);
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 2, 0, 3)) begin
            errors++;
            $display("FAIL mid_idx2: got %h want %h", obs, w(1,0,2,0,3));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 5, 0, 2)) begin
            errors++;
            $display("FAIL mid_idx5: got %h want %h", obs, w(1,0,5,0,2));
        end
        @(posedge clk);                     // index 5 handshaken; 7 now pending
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", obs, w(0,1,0,0,0));
        end
        #3 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== w(0, 1, 0, 0, 0)) begin
                errors++;
                $display("FAIL mid_no_idx7[%0d]: got %h want %h", c, obs, w(0,1,0,0,0));
            end
        end
        load(8'h01);
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 0, 1, 1)) begin
            errors++;
            $display("FAIL mid_next: got %h want %h", obs, w(1,0,0,1,1));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL mid_next_idle: got %h want %h", obs, w(0,1,0,0,0));
        end
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_vec   = 8'h03;
        @(posedge clk); #1;                 // 0x03 accepted
        bus.in_vec = 8'h80;                 // in_valid stays high
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 0, 0, 2)) begin
            errors++;
            $display("FAIL b2b_idx0: got %h want %h", obs, w(1,0,0,0,2));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 1, 1, 1)) begin
            errors++;
            $display("FAIL b2b_idx1: got %h want %h", obs, w(1,0,1,1,1));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL b2b_bubble: got %h want %h", obs, w(0,1,0,0,0));
        end
        @(posedge clk); #1;                 // 0x80 accepted
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
        @(negedge clk);
        checks++;
        if (obs !== w(1, 0, 7, 1, 1)) begin
            errors++;
            $display("FAIL b2b_idx7: got %h want %h", obs, w(1,0,7,1,1));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== w(0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL b2b_idle: got %h want %h", obs, w(0,1,0,0,0));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_zero();
        test_full();
        test_reset_midscan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/onehot_index_scanner.md
# onehot_index_scanner

Sequential encoder converting a DEPTH-bit flag vector into a stream of bit indices, the inverse of the team's index-to-one-hot decoder. It accepts a vector on a valid/ready input handshake and emits the index of every set bit, lowest first, one per output handshake. In the core it drains pending-flag vectors (e.g. writeback/hazard pending bits) into register-file index sequences.

## Interface
- DEPTH, 8, vector width; power of two, ≥ 2
- BITS, $clog2(DEPTH), index width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_vec is valid
- in_ready  out  1  block can accept a vector
- in_vec  in  DEPTH  flag vector; sampled only on the input handshake
- out_valid  out  1  out_index is valid
- out_ready  in  1  consumer accepts out_index
- out_index  out  BITS  index of the lowest remaining set bit
- out_last  out  1  out_index is the final index of this vector
- out_remaining  out  BITS+1  count of set bits still pending, including the current one
- zero_drop  out  1  one-cycle pulse: an all-zero vector was accepted and discarded

## Operation
- Registered state: FSM {IDLE, SCAN}, pending[DEPTH-1:0], zero_drop flop.
- IDLE: in_ready=1, out_valid=0.
  - in_valid=1, in_vec≠0: pending<=in_vec, go SCAN.
  - in_valid=1, in_vec=0: stay IDLE, zero_drop=1 next cycle only; no output produced.
- SCAN: in_ready=0, out_valid=1.
  - out_index = position of lowest set bit of pending (priority low→high).
  - out_last = 1 iff popcount(pending)=1.
  - out_remaining = popcount(pending); never 0 in SCAN.
  - out_valid&&out_ready: clear bit out_index in pending; if out_last, go IDLE.
  - Without out_ready: pending, out_index, out_last, out_remaining held unchanged.
- out_index, out_last, out_remaining, in_ready, out_valid are decoded from registers only; no combinational path from any input to any output.
- In IDLE: out_index=0, out_last=0, out_remaining=0.
- in_vec bits ≥ DEPTH do not exist; out_remaining width BITS+1 covers the all-ones case (DEPTH).

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately): state IDLE, pending=0, zero_drop=0 → in_ready=1, out_valid=0, out_index=0, out_last=0, out_remaining=0.
- Reset asserted mid-scan: remaining indices are dropped; no further out_valid after release until a new vector is accepted.
- Latency: vector accepted at edge N → out_valid=1 with first index in cycle after N.
- Throughput: one index per cycle with out_ready held high; a vector of k set bits occupies k cycles in SCAN.
- Last handshake at edge M → IDLE, in_ready=1 in cycle after M; next vector earliest accepted at edge M+1 (one bubble between vectors).
- zero_drop high exactly one cycle after the accepting edge; back-to-back zero vectors give a pulse each cycle.
- out_valid never deasserts without a handshake except by reset.

## Test plan
- Reset: rst_n=0 mid-cycle → out_valid=0, in_ready=1, out_index=0, out_remaining=0 immediately, without a clock edge.
- DEPTH=8, in_vec=8'b1010_0100, out_ready=1 → out_index 2,5,7 on three consecutive cycles, out_remaining 3,2,1, out_last only with 7; in_ready=1 the following cycle.
- Same vector, out_ready=0 for 3 cycles after out_valid rises → out_index=2, out_remaining=3 held stable for all 3 cycles; then 2,5,7 resume.
- in_vec=8'h00 with in_valid=1 → no out_valid, zero_drop=1 for exactly one cycle, in_ready stays 1.
- in_vec=8'hFF → indices 0..7 in order, out_remaining 8 down to 1, out_last on 7; in_vec=8'h80 → single index 7, out_last=1, out_remaining=1.
- rst_n pulsed low after index 5 of 8'b1010_0100 → outputs return to reset values; after release no index 7 emitted; next vector 8'h01 yields index 0 normally.
